// File: rtl/param_mac.sv
// param_mac: pipelined signed multiply-accumulate with runtime vector length and wrap/saturate modes
module param_mac #(
    parameter  int DATA_W      = 8,
    parameter  int ACC_W       = 16,
    parameter  int MULT_STAGES = 6,
    parameter  int MAX_VEC     = 8,
    localparam int CNT_W       = $clog2(MAX_VEC + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     valid_in,
    input  logic        [CNT_W-1:0]  vec_len,
    input  logic                     sat_en,
    input  logic                     clear,
    output logic signed [ACC_W-1:0]  f,
    output logic                     valid_out,
    output logic                     overflow
);

    localparam int PW = 2 * DATA_W;
    localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_VEC);
    localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [DATA_W-1:0] a_q, b_q;
    logic                     in_v;
    logic signed [PW-1:0]     ax, bx;
    logic signed [PW-1:0]     mp [MULT_STAGES];
    logic [MULT_STAGES-1:0]   mv;
    logic signed [ACC_W-1:0]  p_q;
    logic                     p_v;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         eff_len;
    logic                     last;
    logic signed [ACC_W:0]    sum;
    logic                     ovf;
    logic signed [ACC_W-1:0]  acc_nxt;

    // Operands sign-extended to full product width so the multiply is exact
    assign ax = PW'(a_q);
    assign bx = PW'(b_q);

    // Input register: capture operands of an accepted element
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            in_v <= 1'b0;
        end else if (clear) begin
            a_q  <= '0;
            b_q  <= '0;
            in_v <= 1'b0;
        end else begin
            in_v <= valid_in;
            if (valid_in) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    // Multiplier pipeline: product and valid advance together each cycle, keeping bubbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mv <= '0;
            for (int i = 0; i < MULT_STAGES; i++) mp[i] <= '0;
        end else if (clear) begin
            mv <= '0;
            for (int i = 0; i < MULT_STAGES; i++) mp[i] <= '0;
        end else begin
            mv[0] <= in_v;
            mp[0] <= ax * bx;
            for (int i = 1; i < MULT_STAGES; i++) begin
                mv[i] <= mv[i-1];
                mp[i] <= mp[i-1];
            end
        end
    end

    // Product register: product sign-extended to accumulator width
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q <= '0;
            p_v <= 1'b0;
        end else if (clear) begin
            p_q <= '0;
            p_v <= 1'b0;
        end else begin
            p_q <= ACC_W'(mp[MULT_STAGES-1]);
            p_v <= mv[MULT_STAGES-1];
        end
    end

    // Accumulate datapath: effective length, one-bit-wider sum, overflow and clamp
    always_comb begin
        eff_len = (vec_len == '0) ? CNT_W'(1) : (vec_len > MAXV) ? MAXV : vec_len;
        last    = cnt == eff_len - CNT_W'(1);
        sum     = (ACC_W+1)'(f) + (ACC_W+1)'(p_q);
        ovf     = sum[ACC_W] != sum[ACC_W-1];
        acc_nxt = (cnt == '0)       ? p_q :
                  (!ovf || !sat_en) ? sum[ACC_W-1:0] :
                  sum[ACC_W]        ? AMIN : AMAX;
    end

    // Accumulator, sticky overflow, element counter and completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f         <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
            cnt       <= '0;
        end else if (clear) begin
            f         <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
            cnt       <= '0;
        end else begin
            valid_out <= p_v && last;
            if (p_v) begin
                f        <= acc_nxt;
                overflow <= (cnt == '0) ? 1'b0 : (overflow | ovf);
                cnt      <= last ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_param_mac.sv
// tb_param_mac: directed self-checking bench for param_mac
module tb_param_mac;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic signed [7:0] a = '0;
    logic signed [7:0] b = '0;
    logic              valid_in = 1'b0;
    logic [3:0]        vec_len = 4'd3;
    logic              sat_en = 1'b0;
    logic              clear = 1'b0;
    logic signed [15:0] f;
    logic              valid_out;
    logic              overflow;

    int cyc = 0;
    int last_k = 0;
    int n_cmp = 0;
    int n_err = 0;

    param_mac dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
        .vec_len(vec_len), .sat_en(sat_en), .clear(clear),
        .f(f), .valid_out(valid_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Rising-edge counter; at a falling edge it equals the number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one element at a falling edge; it is sampled at the next rising edge
    task automatic feed(input int x, input int y, input int gap);
        a = 8'(x);
        b = 8'(y);
        valid_in = 1'b1;
        last_k = cyc + 1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic basic(input int gap);
        feed(3, 4, gap);
        feed(-5, 6, gap);
        feed(7, -2, 0);
    endtask

    task automatic same3(input int x, input int y);
        repeat (3) feed(x, y, 0);
    endtask

    // Watch a bounded window for completion pulses and check them
    task automatic collect(input string tag, input int n_exp, input int f0, input int f1, input int ov_exp);
        int n = 0;
        int t [2] = '{-999, -999};
        int fv [2] = '{-99999, -99999};
        int ovl = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (valid_out) begin
                if (n < 2) begin
                    t[n] = cyc;
                    fv[n] = int'(f);
                end
                ovl = int'(overflow);
                n++;
            end
        end
        check({tag, ".count"}, n, n_exp);
        check({tag, ".f"}, fv[0], f0);
        check({tag, ".ovf"}, ovl, ov_exp);
        check({tag, ".lat"}, t[n_exp-1] - last_k, 8);
        check({tag, ".hold"}, int'(f), (n_exp == 2) ? f1 : f0);
        if (n_exp == 2) begin
            check({tag, ".f2"}, fv[1], f1);
            check({tag, ".gap"}, t[1] - t[0], 1);
        end
    endtask

    task automatic no_stray(input string tag);
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (valid_out) n++;
        end
        check(tag, n, 0);
    endtask

    initial begin
        #1;
        check("rst.f", int'(f), 0);
        check("rst.vout", int'(valid_out), 0);
        check("rst.ovf", int'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        basic(0);
        collect("basic", 1, -32, 0, 0);

        same3(127, 127);
        collect("pos_wrap", 1, -17149, 0, 1);
        sat_en = 1'b1;
        same3(127, 127);
        collect("pos_sat", 1, 32767, 0, 1);
        same3(1, 1);
        collect("after_ovf", 1, 3, 0, 0);
        same3(-128, 127);
        collect("neg_sat", 1, -32768, 0, 1);
        sat_en = 1'b0;
        same3(-128, 127);
        collect("neg_wrap", 1, 16768, 0, 1);

        basic(2);
        collect("bubble2", 1, -32, 0, 0);
        basic(5);
        collect("bubble5", 1, -32, 0, 0);

        feed(3, 4, 0);
        feed(-5, 6, 0);
        reset = 1'b0;
        #1;
        check("rstmid.f", int'(f), 0);
        check("rstmid.vout", int'(valid_out), 0);
        check("rstmid.ovf", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        no_stray("rstmid.stray");
        basic(0);
        collect("after_rst", 1, -32, 0, 0);

        same3(127, 127);
        collect("pre_clr", 1, -17149, 0, 1);
        feed(3, 4, 0);
        feed(-5, 6, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr.f", int'(f), 0);
        check("clr.vout", int'(valid_out), 0);
        check("clr.ovf", int'(overflow), 0);
        no_stray("clr.stray");
        basic(0);
        collect("after_clr", 1, -32, 0, 0);

        vec_len = 4'd1;
        feed(2, 3, 0);
        feed(4, 5, 0);
        collect("len1", 2, 6, 20, 0);
        vec_len = 4'd0;
        feed(2, 3, 0);
        feed(4, 5, 0);
        collect("len0", 2, 6, 20, 0);
        vec_len = 4'd8;
        repeat (8) feed(1, 1, 0);
        collect("len8", 1, 8, 0, 0);
        vec_len = 4'd15;
        repeat (8) feed(1, 1, 0);
        collect("len15", 1, 8, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
